// File: rtl/sdf_bfly_stage_16_pkg.sv
// ============================================================================
//  Package    : sdf_bfly_stage_16_pkg
//  Purpose    : Shared definitions for the 64-point SDF FFT stages: sample and
//               twiddle widths, delay depth and the twiddle-ROM phase encoding.
//  Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

package sdf_bfly_stage_16_pkg;

    localparam int DW      = 24;  // signed sample width (re and im)
    localparam int TW_FRAC = 8;   // twiddle fraction bits, 256 = +1.0
    localparam int DEPTH   = 16;  // delay-line depth of this stage
    localparam int N_FFT   = 64;  // transform length

    // Phase reported by the twiddle ROM alongside each twiddle value.
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,  // first half-frame: load the delay line
        ST_BFLY = 2'd1,  // sum out, difference back into the delay line
        ST_TWID = 2'd2,  // twiddled difference out, next frame loads
        ST_RSVD = 2'd3   // never driven; handled like ST_TWID
    } rom_state_e;

endpackage

`default_nettype wire

// File: rtl/sdf_bfly_stage_16_cmul_q8.sv
// ============================================================================
//  Module     : sdf_bfly_stage_16_cmul_q8
//  Purpose    : Purely combinational complex multiply a * b with a Q-format
//               rescale: full-width products, arithmetic shift right by
//               TW_FRAC, result truncated (wrapped) back to DW bits.
//  Ports      : a_r_i/a_i_i  DW  data operand (re/im)
//               b_r_i/b_i_i  DW  twiddle operand (re/im), TW_FRAC fraction bits
//               p_r_o/p_i_o  DW  rescaled product (re/im)
//  Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module sdf_bfly_stage_16_cmul_q8 #(
    parameter int DW      = 24,
    parameter int TW_FRAC = 8
) (
    input  logic signed [DW-1:0] a_r_i,
    input  logic signed [DW-1:0] a_i_i,
    input  logic signed [DW-1:0] b_r_i,
    input  logic signed [DW-1:0] b_i_i,
    output logic signed [DW-1:0] p_r_o,
    output logic signed [DW-1:0] p_i_o
);

    // Operands are sign-extended to 2*DW so every product is exact at 2*DW bits.
    logic signed [2*DW-1:0] w_ar;
    logic signed [2*DW-1:0] w_ai;
    logic signed [2*DW-1:0] w_br;
    logic signed [2*DW-1:0] w_bi;
    logic signed [2*DW-1:0] w_re_full;
    logic signed [2*DW-1:0] w_im_full;

    assign w_ar = {{DW{a_r_i[DW-1]}}, a_r_i};
    assign w_ai = {{DW{a_i_i[DW-1]}}, a_i_i};
    assign w_br = {{DW{b_r_i[DW-1]}}, b_r_i};
    assign w_bi = {{DW{b_i_i[DW-1]}}, b_i_i};

    assign w_re_full = (w_ar * w_br) - (w_ai * w_bi);
    assign w_im_full = (w_ar * w_bi) + (w_ai * w_br);

    // Arithmetic shift removes the twiddle scale; the cast wraps to DW bits.
    assign p_r_o = DW'(w_re_full >>> TW_FRAC);
    assign p_i_o = DW'(w_im_full >>> TW_FRAC);

endmodule

`default_nettype wire

// File: rtl/sdf_bfly_stage_16.sv
// ============================================================================
//  Module     : sdf_bfly_stage_16
//  Purpose    : Radix-2 single-path delay-feedback butterfly stage, 16 deep.
//               Emits x[n]+x[n+16] during the ROM butterfly phase and
//               (x[n]-x[n+16])*W32^n during the twiddle phase.
//  Ports      : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               in_valid   din_r/din_i carry a sample
//               din_r/i    DW   input sample
//               state      2    ROM phase (fill / butterfly / twiddle)
//               w_r/w_i    DW   twiddle from the ROM, this cycle
//               out_valid  dout_r/dout_i valid
//               dout_r/i   DW   output sample (registered)
//  Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module sdf_bfly_stage_16 #(
    parameter int DW      = sdf_bfly_stage_16_pkg::DW,
    parameter int DEPTH   = sdf_bfly_stage_16_pkg::DEPTH,
    parameter int TW_FRAC = sdf_bfly_stage_16_pkg::TW_FRAC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] din_r,
    input  logic [DW-1:0] din_i,
    input  logic [1:0]    state,
    input  logic [DW-1:0] w_r,
    input  logic [DW-1:0] w_i,
    output logic          out_valid,
    output logic [DW-1:0] dout_r,
    output logic [DW-1:0] dout_i
);

    import sdf_bfly_stage_16_pkg::*;

    // Delay line; index DEPTH-1 is the oldest entry (D).
    logic [DEPTH-1:0] tag_q;
    logic [DW-1:0]    re_q [DEPTH];
    logic [DW-1:0]    im_q [DEPTH];

    logic             out_valid_q;
    logic [DW-1:0]    dout_r_q;
    logic [DW-1:0]    dout_i_q;

    logic             shift_en;
    logic             push_tag_d;
    logic [DW-1:0]    push_r_d;
    logic [DW-1:0]    push_i_d;
    logic             out_valid_d;
    logic [DW-1:0]    dout_r_d;
    logic [DW-1:0]    dout_i_d;

    logic [DW-1:0]    din_r_z;
    logic [DW-1:0]    din_i_z;
    logic [DW-1:0]    tw_r;
    logic [DW-1:0]    tw_i;
    logic             d_tag;
    logic [DW-1:0]    d_r;
    logic [DW-1:0]    d_i;
    rom_state_e       rom_state;

    // Idle input slots enter the delay line as zeros.
    assign din_r_z   = in_valid ? din_r : '0;
    assign din_i_z   = in_valid ? din_i : '0;
    assign d_tag     = tag_q[DEPTH-1];
    assign d_r       = re_q[DEPTH-1];
    assign d_i       = im_q[DEPTH-1];
    assign rom_state = rom_state_e'(state);

    sdf_bfly_stage_16_cmul_q8 #(
        .DW      (DW),
        .TW_FRAC (TW_FRAC)
    ) u_cmul (
        .a_r_i (d_r),
        .a_i_i (d_i),
        .b_r_i (w_r),
        .b_i_i (w_i),
        .p_r_o (tw_r),
        .p_i_o (tw_i)
    );

    always_comb begin
        shift_en    = 1'b1;
        push_tag_d  = in_valid;
        push_r_d    = din_r_z;
        push_i_d    = din_i_z;
        out_valid_d = 1'b0;
        dout_r_d    = '0;
        dout_i_d    = '0;
        case (rom_state)
            ST_FILL: begin
                // Only the fill phase waits for data; later phases free-run
                // with the ROM counter.
                shift_en   = in_valid;
                push_tag_d = 1'b1;
            end
            ST_BFLY: begin
                // An entry without a live partner is dropped here so that a
                // partial frame cannot produce a twiddled output later.
                push_tag_d  = in_valid & d_tag;
                push_r_d    = d_r - din_r_z;
                push_i_d    = d_i - din_i_z;
                out_valid_d = in_valid & d_tag;
                dout_r_d    = d_r + din_r_z;
                dout_i_d    = d_i + din_i_z;
            end
            default: begin
                // Twiddle phase (and the unreachable code 3).
                out_valid_d = d_tag;
                dout_r_d    = tw_r;
                dout_i_d    = tw_i;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else if (shift_en) begin
            tag_q   <= {tag_q[DEPTH-2:0], push_tag_d};
            re_q[0] <= push_r_d;
            im_q[0] <= push_i_d;
            for (int i = 1; i < DEPTH; i++) begin
                re_q[i] <= re_q[i-1];
                im_q[i] <= im_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            dout_r_q    <= '0;
            dout_i_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            dout_r_q    <= dout_r_d;
            dout_i_q    <= dout_i_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout_r    = dout_r_q;
    assign dout_i    = dout_i_q;

endmodule

`default_nettype wire
